// File: rtl/host_cmd_sequencer.sv
// Host-side command sequencer driving a controller's enable/mode/in_data pins.
// Define HOST_SEQ_MSB_FIRST_EN to serialize LOAD payloads MSB-first instead of LSB-first.
module host_cmd_sequencer #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_type,
    input  logic [31:0]         cmd_mode,
    input  logic [DATA_W-1:0]   cmd_data,
    input  logic [LEN_W-1:0]    cmd_len,
    output logic                ctrl_enable,
    output logic [31:0]         ctrl_mode,
    output logic signed [31:0]  ctrl_in_data,
    input  logic signed [31:0]  ctrl_out_data,
    output logic                res_valid,
    output logic [DATA_W-1:0]   res_data,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  cnt;
    logic [DATA_W-1:0] data;
    logic              accept;

    // cnt holds the cycles left including the current one, so cnt==1 marks the final cycle
    assign cmd_ready = (state == IDLE) || (cnt == LEN_W'(1));
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);

`ifdef HOST_SEQ_MSB_FIRST_EN
    // Shifting past the payload width yields 0, which covers indices >= DATA_W
    function automatic logic bit_at(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] idx);
        logic [DATA_W-1:0] s;
        s = d >> idx;
        return s[0];
    endfunction
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            data         <= '0;
            ctrl_enable  <= 1'b0;
            ctrl_mode    <= '0;
            ctrl_in_data <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
        end else begin
            ctrl_enable <= 1'b1;
            res_valid   <= 1'b0;

            if (state == RUN && cnt == LEN_W'(1)) begin
                res_valid <= 1'b1;
                res_data  <= ctrl_out_data[DATA_W-1:0];
            end

            if (accept && cmd_len != '0) begin
                state     <= cmd_type ? RUN : LOAD;
                cnt       <= cmd_len;
                ctrl_mode <= cmd_mode;
                if (cmd_type) begin
                    ctrl_in_data <= '0;
                end else begin
`ifdef HOST_SEQ_MSB_FIRST_EN
                    ctrl_in_data <= {{31{1'b0}}, bit_at(cmd_data, cmd_len - LEN_W'(1))};
                    data         <= cmd_data;
`else
                    ctrl_in_data <= {{31{1'b0}}, cmd_data[0]};
                    data         <= cmd_data >> 1;
`endif
                end
            end else if (state != IDLE && cnt > LEN_W'(1)) begin
                cnt <= cnt - LEN_W'(1);
                if (state == LOAD) begin
`ifdef HOST_SEQ_MSB_FIRST_EN
                    // The bit emitted next has index (new cnt - 1) = cnt - 2
                    ctrl_in_data <= {{31{1'b0}}, bit_at(data, cnt - LEN_W'(2))};
`else
                    ctrl_in_data <= {{31{1'b0}}, data[0]};
                    data         <= data >> 1;
`endif
                end
            end else begin
                state        <= IDLE;
                cnt          <= '0;
                ctrl_mode    <= '0;
                ctrl_in_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_host_cmd_sequencer.sv
// Directed self-checking bench for host_cmd_sequencer; expectations follow HOST_SEQ_MSB_FIRST_EN.
module tb_host_cmd_sequencer;

    logic               clk;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_type;
    logic [31:0]        cmd_mode;
    logic [31:0]        cmd_data;
    logic [15:0]        cmd_len;
    logic               ctrl_enable;
    logic [31:0]        ctrl_mode;
    logic signed [31:0] ctrl_in_data;
    logic signed [31:0] ctrl_out_data;
    logic               res_valid;
    logic [31:0]        res_data;
    logic               busy;

    int total;
    int bad;

    host_cmd_sequencer #(.DATA_W(32), .LEN_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_type(cmd_type),
        .cmd_mode(cmd_mode),
        .cmd_data(cmd_data),
        .cmd_len(cmd_len),
        .ctrl_enable(ctrl_enable),
        .ctrl_mode(ctrl_mode),
        .ctrl_in_data(ctrl_in_data),
        .ctrl_out_data(ctrl_out_data),
        .res_valid(res_valid),
        .res_data(res_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic typ, input logic [31:0] mode,
                                 input logic [31:0] dat, input logic [15:0] len);
        cmd_type  = typ;
        cmd_mode  = mode;
        cmd_data  = dat;
        cmd_len   = len;
        cmd_valid = 1'b1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_mode"}, ctrl_mode, 32'h0);
        checkOutput({tag, "_in"}, ctrl_in_data, 32'h0);
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] exp_basic;
        logic [2:0] exp_b2b_a;
        logic [1:0] exp_b2b_b;
        logic       exp_bit;
`ifdef HOST_SEQ_MSB_FIRST_EN
        exp_basic = 4'b1010;
        exp_b2b_a = 3'b011;
`else
        exp_basic = 4'b0101;
        exp_b2b_a = 3'b110;
`endif
        exp_b2b_b = 2'b11;
        total = 0;
        bad   = 0;

        // Reset held with a command pending
        reset         = 1'b0;
        ctrl_out_data = 32'sd0;
        applyStimulus(1'b0, 32'h142, 32'h5, 16'd4);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput("rst_enable", {31'b0, ctrl_enable}, 32'h0);
            checkOutput("rst_resvalid", {31'b0, res_valid}, 32'h0);
            checkOutput("rst_resdata", res_data, 32'h0);
            checkOutput("rst_ready", {31'b0, cmd_ready}, 32'h1);
            checkIdle("rst");
        end
        cmd_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        checkOutput("enable_release", {31'b0, ctrl_enable}, 32'h1);
        checkIdle("post_rst");

        // LOAD basic, payload changed after accept
        applyStimulus(1'b0, 32'h0142, 32'h5, 16'd4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                cmd_valid = 1'b0;
                cmd_data  = 32'hFFFF_FFFF;
            end
            checkOutput("load_mode", ctrl_mode, 32'h142);
            checkOutput("load_bit", ctrl_in_data, {31'b0, exp_basic[k]});
            checkOutput("load_busy", {31'b0, busy}, 32'h1);
        end
        @(negedge clk);
        checkIdle("load_end");

        // Back-to-back LOADs with no gap
        applyStimulus(1'b0, 32'h0142, 32'h6, 16'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) applyStimulus(1'b0, 32'h0102, 32'h3, 16'd2);
            checkOutput("b2b_mode_a", ctrl_mode, 32'h142);
            checkOutput("b2b_bit_a", ctrl_in_data, {31'b0, exp_b2b_a[k]});
            checkOutput("b2b_ready_a", {31'b0, cmd_ready}, (k == 2) ? 32'h1 : 32'h0);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 0) cmd_valid = 1'b0;
            checkOutput("b2b_mode_b", ctrl_mode, 32'h102);
            checkOutput("b2b_bit_b", ctrl_in_data, {31'b0, exp_b2b_b[k]});
            checkOutput("b2b_ready_b", {31'b0, cmd_ready}, (k == 1) ? 32'h1 : 32'h0);
        end
        @(negedge clk);
        checkIdle("b2b_end");

        // LOAD longer than the payload width
        applyStimulus(1'b0, 32'h0055, 32'hFFFF_FFFF, 16'd34);
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            if (k == 0) cmd_valid = 1'b0;
`ifdef HOST_SEQ_MSB_FIRST_EN
            exp_bit = (k >= 2);
`else
            exp_bit = (k < 32);
`endif
            checkOutput("long_bit", ctrl_in_data, {31'b0, exp_bit});
        end
        @(negedge clk);
        checkIdle("long_end");

        // RUN capture of a negative result
        ctrl_out_data = 32'sh1234;
        applyStimulus(1'b1, 32'h008a_1401, 32'h0, 16'd96);
        for (int c = 1; c <= 96; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            checkOutput("run_resvalid", {31'b0, res_valid}, 32'h0);
            if (c == 1 || c == 50 || c == 96) begin
                checkOutput("run_mode", ctrl_mode, 32'h008a_1401);
                checkOutput("run_in", ctrl_in_data, 32'h0);
            end
            if (c == 96) ctrl_out_data = -32'sd7;
        end
        @(negedge clk);
        checkOutput("run_pulse", {31'b0, res_valid}, 32'h1);
        checkOutput("run_resdata", res_data, 32'hFFFF_FFF9);
        checkIdle("run_end");
        @(negedge clk);
        checkOutput("run_pulse_end", {31'b0, res_valid}, 32'h0);
        checkOutput("run_resdata_hold", res_data, 32'hFFFF_FFF9);

        // Zero-length commands from IDLE
        applyStimulus(1'b1, 32'h0055, 32'h0, 16'd0);
        @(negedge clk);
        checkIdle("zero_run");
        checkOutput("zero_run_rv", {31'b0, res_valid}, 32'h0);
        applyStimulus(1'b0, 32'h0066, 32'h1, 16'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkIdle("zero_load");
        @(negedge clk);
        checkOutput("zero_load_rv", {31'b0, res_valid}, 32'h0);

        // Zero-length command accepted on the last cycle of a LOAD
        applyStimulus(1'b0, 32'h0077, 32'h1, 16'd2);
        @(negedge clk);
        applyStimulus(1'b1, 32'h0099, 32'h0, 16'd0);
        checkOutput("zlast_mode1", ctrl_mode, 32'h77);
        @(negedge clk);
        checkOutput("zlast_mode2", ctrl_mode, 32'h77);
        checkOutput("zlast_ready", {31'b0, cmd_ready}, 32'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkIdle("zlast_end");
        @(negedge clk);
        checkOutput("zlast_rv", {31'b0, res_valid}, 32'h0);

        // Abort a RUN with reset at cycle 40
        ctrl_out_data = 32'sh11;
        applyStimulus(1'b1, 32'h008a_1401, 32'h0, 16'd96);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
        end
        checkOutput("abort_pre_busy", {31'b0, busy}, 32'h1);
        #2 reset = 1'b0;
        #1;
        checkIdle("abort");
        checkOutput("abort_enable", {31'b0, ctrl_enable}, 32'h0);
        checkOutput("abort_rv", {31'b0, res_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            checkOutput("abort_no_rv", {31'b0, res_valid}, 32'h0);
        end
        checkOutput("abort_resdata", res_data, 32'h0);

        // RUN after the abort completes normally
        ctrl_out_data = 32'sh2a;
        applyStimulus(1'b1, 32'h0000_0301, 32'h0, 16'd5);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            checkOutput("rerun_mode", ctrl_mode, 32'h301);
            checkOutput("rerun_rv", {31'b0, res_valid}, 32'h0);
        end
        @(negedge clk);
        checkOutput("rerun_pulse", {31'b0, res_valid}, 32'h1);
        checkOutput("rerun_resdata", res_data, 32'h2a);
        checkIdle("rerun_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
